// File: rtl/frame_seq_ctrl_if.sv
// rtl/frame_seq_ctrl_if.sv - config handshake bundle for the frame sequencer
interface frame_seq_ctrl_if #(
    parameter int HW = 16,
    parameter int VW = 13,
    parameter int FW = 8
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [HW-1:0] cfg_h_total;
    logic [HW-1:0] cfg_h_bp;
    logic [VW-1:0] cfg_v_total;
    logic [VW-1:0] cfg_v_bp;
    logic [FW-1:0] cfg_num_frames;

    modport master (
        output cfg_valid, cfg_h_total, cfg_h_bp, cfg_v_total, cfg_v_bp, cfg_num_frames,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_h_total, cfg_h_bp, cfg_v_total, cfg_v_bp, cfg_num_frames,
        output cfg_ready
    );
endinterface

// File: rtl/frame_seq_ctrl.sv
// rtl/frame_seq_ctrl.sv - HD/VD frame sequencer; FRAME_SEQ_CONTINUOUS_EN enables free-run on num_frames==0
module frame_seq_ctrl #(
    parameter int HW         = 16,
    parameter int VW         = 13,
    parameter int FW         = 8,
    parameter int ARM_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    frame_seq_ctrl_if.slave    cfg,
    input  logic               start,
    input  logic               abort,
    output logic               HD,
    output logic               VD,
    output logic [HW-1:0]      hcnt,
    output logic [VW-1:0]      vcnt,
    output logic [FW-1:0]      frame_idx,
    output logic               busy,
    output logic               frame_done,
    output logic               seq_done
);
    localparam int AW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [HW-1:0] r_h_total, r_h_bp, r_hcnt;
    logic [VW-1:0] r_v_total, r_v_bp, r_vcnt;
    logic [FW-1:0] r_num_frames, r_frame_idx;
    logic [AW-1:0] r_arm_cnt;
    logic          r_cfg_loaded;
    logic          r_frame_done;

    logic          w_free_run;
    logic          w_start_ok;
    logic          w_line_end;
    logic          w_frame_end;
    logic          w_last_frame;
    logic          w_arm_end;
    logic [FW-1:0] w_frame_inc;

`ifdef FRAME_SEQ_CONTINUOUS_EN
    assign w_free_run = (r_num_frames == '0);
`else
    assign w_free_run = 1'b0;
`endif

    assign w_start_ok   = r_cfg_loaded && ((r_num_frames != '0) || w_free_run);
    assign w_line_end   = (r_hcnt == r_h_total);
    assign w_frame_end  = (r_state == S_RUN) && w_line_end && (r_vcnt == r_v_total);
    assign w_frame_inc  = r_frame_idx + FW'(1);
    // free-run never terminates, even when frame_idx wraps back onto num_frames (0)
    assign w_last_frame = !w_free_run && (w_frame_inc == r_num_frames);
    assign w_arm_end    = (r_arm_cnt == AW'(ARM_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start && w_start_ok) w_next = S_ARM;
            S_ARM:  if (w_arm_end) w_next = S_RUN;
            S_RUN:  if (w_frame_end && w_last_frame) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    // geometry only moves in IDLE, so a running sequence always sees a stable config
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_total    <= '0;
            r_h_bp       <= '0;
            r_v_total    <= '0;
            r_v_bp       <= '0;
            r_num_frames <= '0;
            r_cfg_loaded <= 1'b0;
        end else if (r_state == S_IDLE && cfg.cfg_valid) begin
            r_h_total    <= cfg.cfg_h_total;
            r_h_bp       <= cfg.cfg_h_bp;
            r_v_total    <= cfg.cfg_v_total;
            r_v_bp       <= cfg.cfg_v_bp;
            r_num_frames <= cfg.cfg_num_frames;
            r_cfg_loaded <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            r_frame_idx  <= '0;
            r_arm_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else if (abort && r_state != S_IDLE) begin
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            r_frame_idx  <= '0;
            r_arm_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_ARM) begin
                        r_arm_cnt   <= '0;
                        r_frame_idx <= '0;
                    end
                end
                S_ARM: r_arm_cnt <= r_arm_cnt + AW'(1);
                S_RUN: begin
                    r_hcnt <= w_line_end ? '0 : r_hcnt + HW'(1);
                    if (w_line_end)
                        r_vcnt <= (r_vcnt == r_v_total) ? '0 : r_vcnt + VW'(1);
                    if (w_frame_end)
                        r_frame_idx <= w_frame_inc;
                end
                default: begin
                    r_hcnt <= '0;
                    r_vcnt <= '0;
                end
            endcase
        end
    end

    assign cfg.cfg_ready = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign HD            = (r_state == S_RUN) && (r_hcnt > r_h_bp);
    assign VD            = (r_state == S_RUN) && (r_vcnt > r_v_bp);
    assign hcnt          = r_hcnt;
    assign vcnt          = r_vcnt;
    assign frame_idx     = r_frame_idx;
    assign frame_done    = r_frame_done;
    assign seq_done      = (r_state == S_DONE);
endmodule
